// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: drains uart_rx into a show-ahead byte FIFO with overflow and irq.
// Optional idle-line timeout is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AW           = 4,
  parameter int unsigned TIMEOUT_BITS = 40
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic [15:0]   clock_divider,
  input  logic          rx_data_ready,
  input  logic [7:0]    rx_data,
  output logic          rx_read_en,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_valid,
  output logic [AW:0]   count,
  input  logic [AW:0]   watermark,
  output logic          overflow,
  input  logic          overflow_clr,
  output logic          timeout,
  output logic          irq
);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic          rx_read_en_q, rx_read_en_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          irq_q, irq_d;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];

  logic push_req, push_ok, pop, full, level_hit;

  always_comb begin
    state_d      = state_q;
    rx_read_en_d = 1'b0;
    push_req     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_data_ready) begin
          push_req     = 1'b1;
          rx_read_en_d = 1'b1;
          state_d      = ACK;
        end
      end
      ACK:  state_d = WAIT;
      WAIT: if (!rx_data_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
  always_comb begin
    pop        = rd_en && (count_q != '0);
    full       = (count_q == FULL_CNT);
    push_ok    = push_req && (!full || pop);
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    overflow_d = overflow_q;
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok) begin
      mem_d[wr_ptr_q] = rx_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    if (push_req && full && !pop) overflow_d = 1'b1;
    else if (overflow_clr)        overflow_d = 1'b0;
    level_hit = (watermark != '0) && (count_q >= watermark);
    irq_d     = level_hit || overflow_q || timeout;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rx_read_en_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_read_en_q <= rx_read_en_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      irq_q        <= irq_d;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TBW    = $clog2(TIMEOUT_BITS + 1);
  localparam logic [TBW-1:0] TB_MAX = TBW'(TIMEOUT_BITS);

  logic [15:0]    presc_q, presc_d;
  logic [TBW-1:0] bits_q, bits_d;
  logic           timeout_q, timeout_d;
  logic           tmo_clr;

  // Prescaler wraps once per bit time; the bit counter saturates at TIMEOUT_BITS.
  always_comb begin
    tmo_clr = push_ok || pop;
    presc_d = presc_q;
    bits_d  = bits_q;
    if (tmo_clr || (count_q == '0)) begin
      presc_d = '0;
      bits_d  = '0;
    end else if (({1'b0, presc_q} + 17'd1) >= {1'b0, clock_divider}) begin
      presc_d = '0;
      if (bits_q != TB_MAX) bits_d = bits_q + TBW'(1);
    end else begin
      presc_d = presc_q + 16'd1;
    end
    timeout_d = tmo_clr ? 1'b0
                        : (timeout_q || ((bits_d == TB_MAX) && (count_q != '0)));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      presc_q   <= '0;
      bits_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      bits_q    <= bits_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{clock_divider, TIMEOUT_BITS[0]};
  assign timeout    = 1'b0;
`endif

  assign rx_read_en = rx_read_en_q;
  assign rd_valid   = (count_q != '0);
  assign rd_data    = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign irq        = irq_q;

endmodule
